// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction memory and
// feeds the IF/ID register, honouring stall (hold) and redirect (flush) from later stages.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [63:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HOLD} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        present;
  logic [31:0] present_inst;

  assign imem_req  = (state_q == IDLE) && !redirect && !srst;
  assign imem_addr = pc_q;
  assign inst_out  = inst_q;
  assign pc_out    = pc_out_q;
  assign valid_out = valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    present      = 1'b0;
    present_inst = buf_q;

    case (state_q)
      IDLE: begin
        if (redirect) pc_d = redirect_pc;
        else          state_d = WAIT;
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          if (!stall) begin
            present      = 1'b1;
            present_inst = imem_rdata;
            state_d      = IDLE;
          end else begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end
        end
      end
      DROP: begin
        // The response in flight belongs to a squashed path; swallow it.
        if (redirect)    pc_d = redirect_pc;
        if (imem_rvalid) state_d = IDLE;
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = IDLE;
        end else if (!stall) begin
          present      = 1'b1;
          present_inst = buf_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (present) pc_d = pc_q + 64'd4;
  end

  always_comb begin
    inst_d   = inst_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (present) begin
      inst_d   = present_inst;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
    end else if (redirect || !stall) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      buf_q    <= 32'h0;
      inst_q   <= NOP_INST;
      pc_out_q <= 64'h0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random stall/redirect/reset
// traffic, checked cycle by cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        srst, stall, redirect, imem_rvalid;
  logic [63:0] redirect_pc;
  logic [31:0] imem_rdata;
  logic        imem_req, valid_out;
  logic [63:0] imem_addr, pc_out;
  logic [31:0] inst_out;

  logic        w_srst, w_stall, w_redirect, w_rvalid;
  logic [63:0] w_rpc;
  logic [31:0] w_rdata;
  logic        w_req, w_valid;
  logic [63:0] w_addr, w_pc;
  logic [31:0] w_inst;

  fetch_unit dut (
    .clk(clk), .srst(srst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_out(inst_out),
    .pc_out(pc_out), .valid_out(valid_out)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .srst(w_srst), .stall(w_stall), .redirect(w_redirect),
    .redirect_pc(w_rpc), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .inst_out(w_inst),
    .pc_out(w_pc), .valid_out(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the fetch stage: an outstanding request (possibly squashed),
  // an optional parked instruction, and the IF/ID output values.
  logic [63:0] m_pc, m_pcout;
  logic [31:0] m_inst, m_buf;
  logic        m_valid, m_pend, m_kill, m_buf_v;

  // Memory environment: one outstanding request, fixed per-request latency.
  logic        mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;
  int          next_lat;

  logic        req_seen;
  logic [63:0] addr_seen;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hA;
      64'h4:   return 32'hB;
      64'h8:   return 32'hC;
      default: return a[31:0] * 32'h9E3779B1 ^ a[63:32] ^ 32'h5A5A0F0F;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pc = 64'h0; m_pcout = 64'h0; m_inst = NOP; m_buf = 32'h0;
    m_valid = 1'b0; m_pend = 1'b0; m_kill = 1'b0; m_buf_v = 1'b0;
  endtask

  // One clock cycle: drive inputs, check the request side, clock, update the
  // model and memory, then check the registered outputs.
  task automatic applyStimulus(input logic s_srst, input logic s_stall,
                               input logic s_redir, input logic [63:0] s_rpc);
    logic        rv, exp_req, present;
    logic [31:0] rd, pdata;
    rv = !s_srst && mem_busy && (mem_cnt == 0);
    rd = rv ? mem_word(mem_addr) : $urandom;
    srst = s_srst; stall = s_stall; redirect = s_redir; redirect_pc = s_rpc;
    imem_rvalid = rv; imem_rdata = rd;
    #2;
    exp_req = !s_srst && !s_redir && !m_pend && !m_buf_v;
    req_seen = imem_req;
    addr_seen = imem_addr;
    checkOutput("imem_req", {63'h0, imem_req}, {63'h0, exp_req});
    checkOutput("imem_addr", imem_addr, m_pc);
    @(posedge clk);

    if (s_srst) begin
      modelReset();
    end else begin
      present = 1'b0;
      pdata = 32'h0;
      if (m_pend && rv) begin
        if (!m_kill && !s_redir) begin
          if (!s_stall) begin present = 1'b1; pdata = rd; end
          else begin m_buf_v = 1'b1; m_buf = rd; end
        end
        m_pend = 1'b0;
        m_kill = 1'b0;
      end else if (m_pend && s_redir) begin
        m_kill = 1'b1;
      end else if (m_buf_v) begin
        if (s_redir) m_buf_v = 1'b0;
        else if (!s_stall) begin present = 1'b1; pdata = m_buf; m_buf_v = 1'b0; end
      end else if (exp_req) begin
        m_pend = 1'b1;
      end
      if (present) begin
        m_inst = pdata; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 64'd4;
      end else if (s_redir || !s_stall) begin
        m_inst = NOP; m_valid = 1'b0;
      end
      if (s_redir) m_pc = s_rpc;
    end

    if (s_srst || rv) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (!s_srst && req_seen) begin
      mem_busy = 1'b1;
      mem_addr = addr_seen;
      mem_cnt  = next_lat - 1;
    end

    #1;
    checkOutput("valid_out", {63'h0, valid_out}, {63'h0, m_valid});
    checkOutput("inst_out", {32'h0, inst_out}, {32'h0, m_inst});
    checkOutput("pc_out", pc_out, m_pcout);
  endtask

  initial begin
    srst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_srst = 1'b1; w_stall = 1'b0; w_redirect = 1'b0; w_rpc = 64'h0;
    w_rvalid = 1'b0; w_rdata = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = 64'h0; next_lat = 1;
    modelReset();
    @(posedge clk);
    #1;

    $display("[TB] reset and back-to-back fetch");
    applyStimulus(1, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 64'h0);
    checkOutput("rst_valid", {63'h0, valid_out}, 64'h0);
    checkOutput("rst_inst", {32'h0, inst_out}, {32'h0, NOP});
    checkOutput("rst_pc_out", pc_out, 64'h0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("first_req_addr", addr_seen, 64'h0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("fetchA_valid", {63'h0, valid_out}, 64'h1);
    checkOutput("fetchA_inst", {32'h0, inst_out}, 64'hA);
    checkOutput("fetchA_pc", pc_out, 64'h0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("gap_valid", {63'h0, valid_out}, 64'h0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("fetchB_inst", {32'h0, inst_out}, 64'hB);
    checkOutput("fetchB_pc", pc_out, 64'h4);

    $display("[TB] response under stall");
    applyStimulus(0, 0, 0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 64'h0);
      checkOutput("frozen_valid", {63'h0, valid_out}, 64'h0);
    end
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("fetchC_inst", {32'h0, inst_out}, 64'hC);
    checkOutput("fetchC_pc", pc_out, 64'h8);

    $display("[TB] redirect while waiting");
    next_lat = 3;
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("after_hold_addr", addr_seen, 64'hC);
    applyStimulus(0, 0, 1, 64'h100);
    applyStimulus(0, 0, 0, 64'h0);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("dropped_valid", {63'h0, valid_out}, 64'h0);
    next_lat = 1;
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("redir_req", {63'h0, req_seen}, 64'h1);
    checkOutput("redir_addr", addr_seen, 64'h100);

    $display("[TB] redirect coincident with response");
    applyStimulus(0, 0, 1, 64'h200);
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("coinc_req", {63'h0, req_seen}, 64'h1);
    checkOutput("coinc_addr", addr_seen, 64'h200);

    $display("[TB] redirect while holding");
    applyStimulus(0, 1, 0, 64'h0);
    applyStimulus(0, 1, 1, 64'h300);
    checkOutput("hold_redir_valid", {63'h0, valid_out}, 64'h0);
    checkOutput("hold_redir_inst", {32'h0, inst_out}, {32'h0, NOP});
    applyStimulus(0, 0, 0, 64'h0);
    checkOutput("hold_redir_addr", addr_seen, 64'h300);
    checkOutput("hold_buf_gone", {63'h0, valid_out}, 64'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic        r_srst, r_stall, r_redir;
      logic [63:0] r_pc;
      next_lat = $urandom_range(1, 4);
      r_srst   = ($urandom_range(0, 59) == 0);
      r_stall  = ($urandom_range(0, 9) < 3);
      r_redir  = ($urandom_range(0, 9) == 0);
      r_pc     = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                              : {$urandom, $urandom};
      applyStimulus(r_srst, r_stall, r_redir, r_pc);
    end

    $display("[TB] PC wrap from top of address space");
    srst = 1'b1; redirect = 1'b0; stall = 1'b0; imem_rvalid = 1'b0;
    w_srst = 1'b0;
    #2;
    checkOutput("wrap_req", {63'h0, w_req}, 64'h1);
    checkOutput("wrap_req_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(posedge clk);
    #1;
    w_rvalid = 1'b1;
    w_rdata  = 32'hD;
    @(posedge clk);
    #1;
    w_rvalid = 1'b0;
    checkOutput("wrap_valid", {63'h0, w_valid}, 64'h1);
    checkOutput("wrap_pc_out", w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_inst", {32'h0, w_inst}, 64'hD);
    #2;
    checkOutput("wrap_next_addr", w_addr, 64'h0);
    checkOutput("wrap_next_req", {63'h0, w_req}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h00000013, instruction driven on bubbles.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 srst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hazard hold; when 1 the IF/ID stage is not capturing.
REQ-006 redirect  input  1  taken branch/jump from EX/MEM; flush fetch.
REQ-007 redirect_pc  input  64  target PC, valid when redirect=1.
REQ-008 imem_req  output  1  instruction memory request strobe, one cycle per request.
REQ-009 imem_addr  output  64  request address, valid when imem_req=1.
REQ-010 imem_rvalid  input  1  response strobe; latency >=1 cycle; at most one outstanding request.
REQ-011 imem_rdata  input  32  response instruction, valid when imem_rvalid=1.
REQ-012 inst_out  output  32  instruction to IF/ID register din.
REQ-013 pc_out  output  64  PC of inst_out, to IF/ID register pc.
REQ-014 valid_out  output  1  inst_out/pc_out hold a real instruction.

Function
REQ-015 The block SHALL hold a 64-bit pc_r, a 32-bit buffer buf_r, and FSM states IDLE, WAIT, DROP, HOLD.
REQ-016 The block SHALL drive imem_req=1 and imem_addr=pc_r combinationally only in IDLE with redirect=0; otherwise imem_req=0 and imem_addr=pc_r.
REQ-017 IDLE: redirect=1 -> pc_r=redirect_pc, stay IDLE; else -> WAIT.
REQ-018 WAIT, redirect=0, imem_rvalid=1, stall=0: inst_out=imem_rdata, pc_out=pc_r, valid_out=1, pc_r=pc_r+4, -> IDLE.
REQ-019 WAIT, redirect=0, imem_rvalid=1, stall=1: buf_r=imem_rdata, outputs unchanged, -> HOLD.
REQ-020 WAIT, redirect=1: pc_r=redirect_pc; imem_rvalid=1 same cycle -> data discarded, -> IDLE; imem_rvalid=0 -> DROP.
REQ-021 DROP: imem_rvalid=1 -> data discarded, -> IDLE; redirect=1 in DROP -> pc_r=redirect_pc, stays DROP unless imem_rvalid=1.
REQ-022 HOLD: redirect=1 -> buf_r discarded, pc_r=redirect_pc, -> IDLE; stall=0 -> inst_out=buf_r, pc_out=pc_r, valid_out=1, pc_r=pc_r+4, -> IDLE; else stay HOLD.
REQ-023 Output registers SHALL hold their values whenever stall=1 and redirect=0.
REQ-024 In any cycle with stall=0 where REQ-018/REQ-022 do not present an instruction, outputs SHALL become inst_out=NOP_INST, valid_out=0, pc_out unchanged.
REQ-025 redirect=1 SHALL force inst_out=NOP_INST, valid_out=0 next cycle regardless of stall.
REQ-026 Priority SHALL be srst > redirect > imem_rvalid > stall.
REQ-027 pc_r+4 SHALL wrap modulo 2^64; redirect_pc is taken unaligned as given.
REQ-028 Fetch latency SHALL be request cycle + memory latency + 1 cycle to valid_out; zero-stall throughput one instruction per (latency+1) cycles.

Reset
REQ-029 srst=1 at a rising edge SHALL set pc_r=RESET_PC, state=IDLE, buf_r=0, inst_out=NOP_INST, pc_out=0, valid_out=0.
REQ-030 srst mid-WAIT SHALL not wait for imem_rvalid; a response arriving in the first post-reset IDLE/WAIT before the new request SHALL be ignored by the memory contract (memory is reset on the same srst).
REQ-031 imem_req SHALL be 0 during any cycle with srst=1.

Verification
REQ-032 Reset, latency 1, no stall, rdata=32'hA, 32'hB -> valid_out=1 with (pc_out,inst_out)=(0,A) then (4,B), two cycles apart.
REQ-033 Response with stall=1 for 3 cycles, rdata=32'hC at pc 8 -> outputs frozen 3 cycles, then (8,C) valid; next imem_addr=12.
REQ-034 redirect=1, redirect_pc=64'h100 while WAIT, response 2 cycles later -> response dropped, valid_out=0, next imem_addr=64'h100.
REQ-035 redirect and imem_rvalid same cycle in WAIT -> data discarded, following cycle imem_req=1 at redirect_pc.
REQ-036 redirect in HOLD with stall=1 -> buffer discarded, valid_out=0, inst_out=NOP_INST, next fetch at redirect_pc.
REQ-037 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> pc_out=...FFFC, next imem_addr=0.
